rgb2ycbcr_block: RTL

//  Stage directly downstream of the 8x8 block re-orderer in the JPEG encoder. Consumes 8x8 RGB pixel

---
 rtl/jpeg_pkg.sv | 26 ++
 rtl/rgb2ycbcr_pipe.sv | 84 ++++++++
 rtl/rgb2ycbcr_block.sv | 106 ++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared JPEG encoder constants, sideband type and frame sizing helper
package jpeg_pkg;

   localparam int unsigned COEF_YR   = 77;
   localparam int unsigned COEF_YG   = 150;
   localparam int unsigned COEF_YB   = 29;
   localparam int unsigned COEF_CBR  = 43;
   localparam int unsigned COEF_CBG  = 85;
   localparam int unsigned COEF_CRG  = 107;
   localparam int unsigned COEF_CRB  = 21;
   localparam int unsigned COEF_HALF = 128;
   localparam int unsigned COEF_OFS  = 32768;

   typedef struct packed {
      logic valid;
      logic blk_first;
      logic blk_end;
      logic frame_last;
      logic frame_err;
   } ycc_flags_t;

   function automatic int BLKS_PER_FRAME(input int width, input int high);
      return (width * high) / 64;
   endfunction

endpackage

// File: rtl/rgb2ycbcr_pipe.sv
// rtl/rgb2ycbcr_pipe.sv - 3-stage RGB to YCbCr datapath with sideband carried in lockstep
module rgb2ycbcr_pipe
   import jpeg_pkg::*;
#(
   parameter int LEVEL_SHIFT = 1,
   parameter int BLK_CNT_W   = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [23:0]          rgb,
   input  ycc_flags_t           flags_in,
   input  logic [BLK_CNT_W-1:0] cnt_in,
   output logic [7:0]           y,
   output logic [7:0]           cb,
   output logic [7:0]           cr,
   output ycc_flags_t           flags_out,
   output logic [BLK_CNT_W-1:0] cnt_out
);

   logic [7:0] r, g, b;
   assign r = rgb[23:16];
   assign g = rgb[15:8];
   assign b = rgb[7:0];

   logic [16:0]         p_yr, p_yg, p_yb, p_cbr, p_cbg, p_cbb, p_crr, p_crg, p_crb;
   logic signed [17:0]  s_y, s_cb, s_cr;
   ycc_flags_t          flags_s1, flags_s2;
   logic [BLK_CNT_W-1:0] cnt_s1, cnt_s2;

   function automatic logic [16:0] mul_q8(input logic [7:0] v, input int unsigned k);
      return 17'({24'd0, v} * k);
   endfunction

   // Round, drop the Q8 fraction and saturate; level shift is an MSB flip of the clamped byte.
   function automatic logic [7:0] round_clamp(input logic signed [17:0] s);
      logic [18:0] t;
      logic [7:0]  v;
      t = {s[17], s} + 19'd128;
      if (t[18])
         v = 8'd0;
      else if (t[17:16] != 2'b00)
         v = 8'hFF;
      else
         v = t[15:8];
      return (LEVEL_SHIFT != 0) ? {~v[7], v[6:0]} : v;
   endfunction

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         p_yr <= '0; p_yg <= '0; p_yb <= '0;
         p_cbr <= '0; p_cbg <= '0; p_cbb <= '0;
         p_crr <= '0; p_crg <= '0; p_crb <= '0;
         s_y <= '0; s_cb <= '0; s_cr <= '0;
         y <= '0; cb <= '0; cr <= '0;
         flags_s1 <= '0; flags_s2 <= '0; flags_out <= '0;
         cnt_s1 <= '0; cnt_s2 <= '0; cnt_out <= '0;
      end else begin
         p_yr  <= mul_q8(r, COEF_YR);
         p_yg  <= mul_q8(g, COEF_YG);
         p_yb  <= mul_q8(b, COEF_YB);
         p_cbr <= mul_q8(r, COEF_CBR);
         p_cbg <= mul_q8(g, COEF_CBG);
         p_cbb <= mul_q8(b, COEF_HALF);
         p_crr <= mul_q8(r, COEF_HALF);
         p_crg <= mul_q8(g, COEF_CRG);
         p_crb <= mul_q8(b, COEF_CRB);
         flags_s1 <= flags_in;
         cnt_s1   <= cnt_in;

         s_y  <= {1'b0, p_yr} + {1'b0, p_yg} + {1'b0, p_yb};
         s_cb <= 18'(COEF_OFS) + {1'b0, p_cbb} - {1'b0, p_cbr} - {1'b0, p_cbg};
         s_cr <= 18'(COEF_OFS) + {1'b0, p_crr} - {1'b0, p_crg} - {1'b0, p_crb};
         flags_s2 <= flags_s1;
         cnt_s2   <= cnt_s1;

         y  <= round_clamp(s_y);
         cb <= round_clamp(s_cb);
         cr <= round_clamp(s_cr);
         flags_out <= flags_s2;
         cnt_out   <= cnt_s2;
      end
   end

endmodule

// File: rtl/rgb2ycbcr_block.sv
// rtl/rgb2ycbcr_block.sv - 8x8 RGB block to YCbCr converter with block/frame tagging and error flags
module rgb2ycbcr_block
   import jpeg_pkg::*;
#(
   parameter int IMAGE_WIDTH = 1280,
   parameter int IMAGE_HIGH  = 720,
   parameter int LEVEL_SHIFT = 1,
   parameter int BLK_CNT_W   = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [23:0]          jpeg_rgb_data,
   input  logic                 jpeg_rgb_data_en,
   input  logic                 jpeg_rgb_data_last,
   output logic [7:0]           y_data,
   output logic [7:0]           cb_data,
   output logic [7:0]           cr_data,
   output logic                 ycc_en,
   output logic                 ycc_blk_first,
   output logic                 ycc_blk_end,
   output logic                 ycc_frame_last,
   output logic [BLK_CNT_W-1:0] ycc_blk_cnt,
   output logic                 err_short_blk,
   output logic                 err_frame_len
);

   localparam logic [BLK_CNT_W-1:0] LAST_BLK =
      BLK_CNT_W'(BLKS_PER_FRAME(IMAGE_WIDTH, IMAGE_HIGH) - 1);

   logic [5:0]           pix_idx;
   logic [BLK_CNT_W-1:0] blk_cnt;
   logic                 last_seen;
   logic                 cnt_wrapped;
   logic                 is_end;
   logic                 frame_end;
   ycc_flags_t           flags_in;
   ycc_flags_t           flags_out;

   // A frame closes on pixel 63 of the block in which last was seen, including pixel 63 itself.
   always_comb begin
      is_end              = (pix_idx == 6'd63);
      frame_end           = jpeg_rgb_data_en && is_end && (last_seen || jpeg_rgb_data_last);
      flags_in            = '0;
      flags_in.valid      = jpeg_rgb_data_en;
      flags_in.blk_first  = jpeg_rgb_data_en && (pix_idx == 6'd0);
      flags_in.blk_end    = jpeg_rgb_data_en && is_end;
      flags_in.frame_last = frame_end;
      flags_in.frame_err  = frame_end && (cnt_wrapped || (blk_cnt != LAST_BLK));
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pix_idx       <= '0;
         blk_cnt       <= '0;
         last_seen     <= 1'b0;
         cnt_wrapped   <= 1'b0;
         err_short_blk <= 1'b0;
      end else begin
         err_short_blk <= 1'b0;
         if (jpeg_rgb_data_en) begin
            pix_idx <= pix_idx + 6'd1;
            if (is_end) begin
               last_seen <= 1'b0;
               if (frame_end) begin
                  blk_cnt     <= '0;
                  cnt_wrapped <= 1'b0;
               end else begin
                  blk_cnt <= blk_cnt + BLK_CNT_W'(1);
                  if (&blk_cnt)
                     cnt_wrapped <= 1'b1;
               end
            end else if (jpeg_rgb_data_last) begin
               last_seen <= 1'b1;
            end
         end else if (pix_idx != 6'd0) begin
            // Truncated block: abandon it, including any pending frame end.
            pix_idx       <= '0;
            last_seen     <= 1'b0;
            err_short_blk <= 1'b1;
         end
      end
   end

   rgb2ycbcr_pipe #(
      .LEVEL_SHIFT (LEVEL_SHIFT),
      .BLK_CNT_W   (BLK_CNT_W)
   ) u_pipe (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .rgb       (jpeg_rgb_data),
      .flags_in  (flags_in),
      .cnt_in    (blk_cnt),
      .y         (y_data),
      .cb        (cb_data),
      .cr        (cr_data),
      .flags_out (flags_out),
      .cnt_out   (ycc_blk_cnt)
   );

   assign ycc_en         = flags_out.valid;
   assign ycc_blk_first  = flags_out.blk_first;
   assign ycc_blk_end    = flags_out.blk_end;
   assign ycc_frame_last = flags_out.frame_last;
   assign err_frame_len  = flags_out.frame_err;

endmodule
